// File: rtl/cpu64_l1_evict.sv
// L1 eviction/writeback engine: reads the victim line, sends Release/ReleaseData on TL-C,
// waits for ReleaseAck on TL-D and then invalidates the way. Optional watchdog: CPU64_L1_EVICT_WDOG_EN.
module cpu64_l1_evict #(
  parameter  int unsigned INDEX_W   = 5,
  parameter  int unsigned TAG_W     = 21,
  parameter  int unsigned SOURCE_ID = 0,
  localparam int unsigned ADDR_W    = TAG_W + INDEX_W + 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [INDEX_W-1:0] req_set_i,
  input  logic [2:0]         req_way_i,
  input  logic [TAG_W-1:0]   req_tag_i,
  input  logic               req_dirty_i,
  input  logic [1:0]         req_perm_i,
  output logic               da_re_o,
  output logic [INDEX_W-1:0] da_set_o,
  output logic [2:0]         da_way_o,
  output logic [2:0]         da_beat_o,
  input  logic [63:0]        da_rdata_i,
  output logic               c_valid_o,
  input  logic               c_ready_i,
  output logic [2:0]         c_opcode_o,
  output logic [2:0]         c_param_o,
  output logic [2:0]         c_size_o,
  output logic [3:0]         c_source_o,
  output logic [ADDR_W-1:0]  c_address_o,
  output logic [63:0]        c_data_o,
  input  logic               d_valid_i,
  input  logic [2:0]         d_opcode_i,
  output logic               d_ready_o,
  output logic               inv_valid_o,
  output logic [INDEX_W-1:0] inv_set_o,
  output logic [2:0]         inv_way_o,
  output logic               done_o,
  output logic               err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_SEND,
    S_WAIT_ACK,
    S_FIN
  } state_e;

  localparam logic [1:0] PERM_N          = 2'd0;
  localparam logic [1:0] PERM_B          = 2'd1;
  localparam logic [2:0] OP_RELEASE      = 3'd6;
  localparam logic [2:0] OP_RELEASE_DATA = 3'd7;
  localparam logic [2:0] OP_RELEASE_ACK  = 3'd6;
  localparam logic [2:0] PARAM_TTON      = 3'd1;
  localparam logic [2:0] PARAM_BTON      = 3'd2;

  state_e             state_q, state_d;
  logic [2:0]         beat_q, beat_d;
  logic [INDEX_W-1:0] set_q, set_d;
  logic [2:0]         way_q, way_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               dirty_q, dirty_d;
  logic [1:0]         perm_q, perm_d;
  logic [63:0]        data_q, data_d;
  logic               fresh_q, fresh_d;

`ifdef CPU64_L1_EVICT_WDOG_EN
  logic [9:0] wdog_q, wdog_d;
  logic       err_q, err_d;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      set_q   <= '0;
      way_q   <= '0;
      tag_q   <= '0;
      dirty_q <= 1'b0;
      perm_q  <= '0;
      data_q  <= '0;
      fresh_q <= 1'b0;
`ifdef CPU64_L1_EVICT_WDOG_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      set_q   <= set_d;
      way_q   <= way_d;
      tag_q   <= tag_d;
      dirty_q <= dirty_d;
      perm_q  <= perm_d;
      data_q  <= data_d;
      fresh_q <= fresh_d;
`ifdef CPU64_L1_EVICT_WDOG_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
`endif
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    set_d       = set_q;
    way_d       = way_q;
    tag_d       = tag_q;
    dirty_d     = dirty_q;
    perm_d      = perm_q;
    data_d      = data_q;
    fresh_d     = 1'b0;
`ifdef CPU64_L1_EVICT_WDOG_EN
    wdog_d      = wdog_q;
    err_d       = err_q;
`endif
    req_ready_o = 1'b0;
    da_re_o     = 1'b0;
    c_valid_o   = 1'b0;
    d_ready_o   = 1'b0;
    inv_valid_o = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          set_d   = req_set_i;
          way_d   = req_way_i;
          tag_d   = req_tag_i;
          dirty_d = req_dirty_i;
          perm_d  = req_perm_i;
          beat_d  = '0;
          if (req_perm_i == PERM_N) state_d = S_FIN;
          else if (req_dirty_i)     state_d = S_RD;
          else                      state_d = S_SEND;
        end
      end
      S_RD: begin
        da_re_o = 1'b1;
        fresh_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        c_valid_o = 1'b1;
        // Read data is only valid in the first SEND cycle; keep a copy for stalls.
        if (fresh_q) data_d = da_rdata_i;
        if (c_ready_i) begin
          if (dirty_q && beat_q != 3'd7) begin
            beat_d  = beat_q + 3'd1;
            state_d = S_RD;
          end else begin
            state_d = S_WAIT_ACK;
`ifdef CPU64_L1_EVICT_WDOG_EN
            wdog_d  = '0;
`endif
          end
        end
      end
      S_WAIT_ACK: begin
        d_ready_o = (d_opcode_i == OP_RELEASE_ACK);
        if (d_valid_i && d_ready_o) begin
          state_d = S_FIN;
`ifdef CPU64_L1_EVICT_WDOG_EN
        end else if (wdog_q == 10'd1023) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          wdog_d  = wdog_q + 10'd1;
`endif
        end
      end
      S_FIN: begin
        inv_valid_o = 1'b1;
        done_o      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign da_set_o    = set_q;
  assign da_way_o    = way_q;
  assign da_beat_o   = beat_q;
  assign c_opcode_o  = dirty_q ? OP_RELEASE_DATA : OP_RELEASE;
  // Permission 3 is treated like Trunk.
  assign c_param_o   = (perm_q == PERM_B) ? PARAM_BTON : PARAM_TTON;
  assign c_size_o    = 3'd6;
  assign c_source_o  = 4'(SOURCE_ID);
  assign c_address_o = {tag_q, set_q, 6'd0};
  assign c_data_o    = dirty_q ? (fresh_q ? da_rdata_i : data_q) : 64'd0;
  assign inv_set_o   = set_q;
  assign inv_way_o   = way_q;

`ifdef CPU64_L1_EVICT_WDOG_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cpu64_l1_evict.sv
// Testbench for cpu64_l1_evict: table of eviction requests, C-channel scoreboard and
// a small data-array model. Watchdog sequence is compiled in with CPU64_L1_EVICT_WDOG_EN.
module tb_cpu64_l1_evict;
  localparam int INDEX_W = 5;
  localparam int TAG_W   = 21;
  localparam int ADDR_W  = TAG_W + INDEX_W + 6;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               req_valid_i = 1'b0;
  logic               req_ready_o;
  logic [INDEX_W-1:0] req_set_i = '0;
  logic [2:0]         req_way_i = '0;
  logic [TAG_W-1:0]   req_tag_i = '0;
  logic               req_dirty_i = 1'b0;
  logic [1:0]         req_perm_i = '0;
  logic               da_re_o;
  logic [INDEX_W-1:0] da_set_o;
  logic [2:0]         da_way_o;
  logic [2:0]         da_beat_o;
  logic [63:0]        da_rdata_i;
  logic               c_valid_o;
  logic               c_ready_i = 1'b1;
  logic [2:0]         c_opcode_o;
  logic [2:0]         c_param_o;
  logic [2:0]         c_size_o;
  logic [3:0]         c_source_o;
  logic [ADDR_W-1:0]  c_address_o;
  logic [63:0]        c_data_o;
  logic               d_valid_i = 1'b0;
  logic [2:0]         d_opcode_i = '0;
  logic               d_ready_o;
  logic               inv_valid_o;
  logic [INDEX_W-1:0] inv_set_o;
  logic [2:0]         inv_way_o;
  logic               done_o;
  logic               err_o;

  cpu64_l1_evict #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .SOURCE_ID(0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_set_i(req_set_i),
    .req_way_i(req_way_i), .req_tag_i(req_tag_i), .req_dirty_i(req_dirty_i),
    .req_perm_i(req_perm_i),
    .da_re_o(da_re_o), .da_set_o(da_set_o), .da_way_o(da_way_o), .da_beat_o(da_beat_o),
    .da_rdata_i(da_rdata_i),
    .c_valid_o(c_valid_o), .c_ready_i(c_ready_i), .c_opcode_o(c_opcode_o),
    .c_param_o(c_param_o), .c_size_o(c_size_o), .c_source_o(c_source_o),
    .c_address_o(c_address_o), .c_data_o(c_data_o),
    .d_valid_i(d_valid_i), .d_opcode_i(d_opcode_i), .d_ready_o(d_ready_o),
    .inv_valid_o(inv_valid_o), .inv_set_o(inv_set_o), .inv_way_o(inv_way_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] pat(input logic [4:0] s, input logic [2:0] w, input logic [2:0] b);
    return 64'hC0DE_5A5A_0000_0000 ^ {40'd0, s, w, b, 13'd0} ^ {8{5'd0, b}};
  endfunction

  // Array model: data valid exactly one cycle after the strobe, garbage otherwise.
  always @(posedge clk_i)
    da_rdata_i <= da_re_o ? pat(da_set_o, da_way_o, da_beat_o) : 64'hBAD0_BAD0_BAD0_BAD0;

  typedef struct packed {
    logic [2:0]        op;
    logic [2:0]        param;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
  } beat_t;

  typedef struct {
    logic [INDEX_W-1:0] set;
    logic [2:0]         way;
    logic [TAG_W-1:0]   tag;
    logic               dirty;
    logic [1:0]         perm;
    int                 stall_beat;
    int                 stall_cyc;
    int                 ack_dly;
    logic [2:0]         pre_op;
    logic               early_ack;
    int                 rst_beat;
    int                 exp_beats;
    logic [2:0]         exp_opcode;
    logic [2:0]         exp_param;
    int                 exp_last_cyc;
  } vec_t;

  beat_t sb_q[$];
  vec_t  vecs[9];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tg);
    check({tg, ".req_ready"}, req_ready_o, 1);
    check({tg, ".c_valid"},   c_valid_o, 0);
    check({tg, ".da_re"},     da_re_o, 0);
    check({tg, ".d_ready"},   d_ready_o, 0);
    check({tg, ".inv_valid"}, inv_valid_o, 0);
    check({tg, ".done"},      done_o, 0);
    check({tg, ".err"},       err_o, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tg;
    int    cyc, beats_hs, rd_cnt, stall_left, wait_cnt, done_cyc, last_hs;
    bit    acked, done_seen, prev_stall, aborted;
    beat_t e, snap;
    tg = $sformatf("v%0d", idx);
    cyc = 0; beats_hs = 0; rd_cnt = 0; wait_cnt = 0; done_cyc = 0; last_hs = 0;
    stall_left = v.stall_cyc;
    acked = 0; done_seen = 0; prev_stall = 0; aborted = 0;
    snap = '0;
    sb_q.delete();

    @(negedge clk_i);
    check({tg, ".ready_before"}, req_ready_o, 1);
    req_valid_i = 1'b1;
    req_set_i   = v.set;
    req_way_i   = v.way;
    req_tag_i   = v.tag;
    req_dirty_i = v.dirty;
    req_perm_i  = v.perm;
    for (int b = 0; b < v.exp_beats; b++) begin
      e.op    = v.exp_opcode;
      e.param = v.exp_param;
      e.addr  = {v.tag, v.set, 6'd0};
      e.data  = v.dirty ? pat(v.set, v.way, 3'(b)) : 64'd0;
      sb_q.push_back(e);
    end
    @(posedge clk_i); #1;
    // Scramble request fields so late sampling would show up.
    req_valid_i = 1'b0;
    req_set_i   = ~v.set;
    req_way_i   = ~v.way;
    req_tag_i   = ~v.tag;
    req_dirty_i = ~v.dirty;
    req_perm_i  = ~v.perm;
    cyc = 2;

    while (!done_seen && cyc < 400) begin
      // Drive inputs for this cycle.
      c_ready_i = 1'b1;
      if (c_valid_o && beats_hs == v.stall_beat && stall_left > 0) begin
        c_ready_i = 1'b0;
        stall_left--;
      end
      if (acked) d_valid_i = 1'b0;
      else if (v.early_ack) begin
        d_valid_i  = 1'b1;
        d_opcode_i = 3'd6;
      end else if (v.exp_beats > 0 && beats_hs == v.exp_beats) begin
        wait_cnt++;
        if (v.pre_op != 3'd0 && wait_cnt <= 2) begin
          d_valid_i  = 1'b1;
          d_opcode_i = v.pre_op;
        end else if (wait_cnt >= v.ack_dly + ((v.pre_op != 3'd0) ? 2 : 0)) begin
          d_valid_i  = 1'b1;
          d_opcode_i = 3'd6;
        end else d_valid_i = 1'b0;
      end
      if (v.rst_beat >= 0 && beats_hs == v.rst_beat && c_valid_o) begin
        rst_ni  = 1'b0;
        aborted = 1;
        break;
      end

      // Observe this cycle.
      @(negedge clk_i);
      if (da_re_o) begin
        check({tg, ".da_beat"}, da_beat_o, rd_cnt[2:0]);
        check({tg, ".da_set"},  da_set_o, v.set);
        check({tg, ".da_way"},  da_way_o, v.way);
        rd_cnt++;
      end
      if (c_valid_o) begin
        check({tg, ".d_ready_in_send"}, d_ready_o, 0);
        if (prev_stall) begin
          check({tg, ".stall_opcode"}, c_opcode_o, snap.op);
          check({tg, ".stall_param"},  c_param_o, snap.param);
          check({tg, ".stall_addr"},   c_address_o, snap.addr);
          check({tg, ".stall_data"},   c_data_o, snap.data);
        end
        if (c_ready_i) begin
          if (sb_q.size() == 0) check({tg, ".unexpected_beat"}, 1, 0);
          else begin
            e = sb_q.pop_front();
            check($sformatf("%s.b%0d_opcode", tg, beats_hs), c_opcode_o, e.op);
            check($sformatf("%s.b%0d_param", tg, beats_hs),  c_param_o, e.param);
            check($sformatf("%s.b%0d_addr", tg, beats_hs),   c_address_o, e.addr);
            check($sformatf("%s.b%0d_data", tg, beats_hs),   c_data_o, e.data);
          end
          check({tg, ".c_size"},   c_size_o, 6);
          check({tg, ".c_source"}, c_source_o, 0);
          beats_hs++;
          last_hs    = cyc;
          prev_stall = 0;
        end else begin
          snap       = '{op: c_opcode_o, param: c_param_o, addr: c_address_o, data: c_data_o};
          prev_stall = 1;
        end
      end
      if (d_valid_i && d_opcode_i != 3'd6) begin
        check({tg, ".d_ready_other_op"}, d_ready_o, 0);
        check({tg, ".busy_while_wait"},  req_ready_o, 0);
      end
      if (d_valid_i && d_ready_o) begin
        acked = 1;
        check({tg, ".ack_after_last_beat"}, beats_hs, v.exp_beats);
      end
      if (done_o) begin
        check({tg, ".inv_valid"}, inv_valid_o, 1);
        check({tg, ".inv_set"},   inv_set_o, v.set);
        check({tg, ".inv_way"},   inv_way_o, v.way);
        if (v.exp_beats > 0) check({tg, ".done_after_ack"}, acked, 1);
        done_seen = 1;
        done_cyc  = cyc;
      end
      @(posedge clk_i); #1;
      cyc++;
    end

    d_valid_i = 1'b0;
    c_ready_i = 1'b1;
    if (aborted) begin
      #1;
      check_idle_outputs({tg, ".in_reset"});
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check_idle_outputs({tg, ".after_reset"});
      sb_q.delete();
      return;
    end

    check({tg, ".completed_in_budget"}, done_seen, 1);
    if (v.exp_last_cyc > 0)
      check({tg, ".latency"}, (v.exp_beats > 0) ? last_hs : done_cyc, v.exp_last_cyc);
    check({tg, ".beats"},      beats_hs, v.exp_beats);
    check({tg, ".reads"},      rd_cnt, (v.dirty && v.perm != 2'd0) ? 8 : 0);
    check({tg, ".sb_empty"},   sb_q.size(), 0);
    @(negedge clk_i);
    check_idle_outputs({tg, ".post"});
  endtask

  initial begin
    //          set    way   tag            dirty perm  stl_b stl_c ack pre   early rst  beats op    param last
    vecs[0] = '{5'd3,  3'd5, 21'h1ABCD,  1'b1, 2'd2, -1, 0, 2, 3'd0, 1'b0, -1, 8, 3'd7, 3'd1, 17};
    vecs[1] = '{5'd10, 3'd2, 21'h00F0F,  1'b0, 2'd1, -1, 0, 2, 3'd0, 1'b0, -1, 1, 3'd6, 3'd2, 2};
    vecs[2] = '{5'd7,  3'd1, 21'h12345,  1'b0, 2'd0, -1, 0, 2, 3'd0, 1'b0, -1, 0, 3'd0, 3'd0, 2};
    vecs[3] = '{5'd31, 3'd7, 21'h1FFFFF, 1'b1, 2'd3,  4, 3, 1, 3'd0, 1'b0, -1, 8, 3'd7, 3'd1, 20};
    vecs[4] = '{5'd0,  3'd0, 21'h155555, 1'b1, 2'd1, -1, 0, 2, 3'd1, 1'b0, -1, 8, 3'd7, 3'd2, 17};
    vecs[5] = '{5'd12, 3'd3, 21'h0ACE1,  1'b0, 2'd2, -1, 0, 0, 3'd0, 1'b1, -1, 1, 3'd6, 3'd1, 2};
    vecs[6] = '{5'd9,  3'd4, 21'h0BEEF,  1'b1, 2'd2, -1, 0, 2, 3'd0, 1'b0,  3, 8, 3'd7, 3'd1, -1};
    vecs[7] = '{5'd21, 3'd6, 21'h1F00D,  1'b1, 2'd0, -1, 0, 2, 3'd0, 1'b0, -1, 0, 3'd0, 3'd0, 2};
    vecs[8] = '{5'd5,  3'd3, 21'h0CAFE,  1'b1, 2'd2, -1, 0, 2, 3'd0, 1'b0, -1, 8, 3'd7, 3'd1, 17};

    repeat (3) @(negedge clk_i);
    check_idle_outputs("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_idle_outputs("post_reset");

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

`ifdef CPU64_L1_EVICT_WDOG_EN
    begin
      int  wcyc;
      bit  wdone;
      wcyc  = 0;
      wdone = 0;
      @(negedge clk_i);
      req_valid_i = 1'b1;
      req_set_i   = 5'd17;
      req_way_i   = 3'd2;
      req_tag_i   = 21'h0DEAD;
      req_dirty_i = 1'b0;
      req_perm_i  = 2'd2;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      d_valid_i   = 1'b0;
      while (!wdone && wcyc < 1200) begin
        @(negedge clk_i);
        wcyc++;
        if (wcyc == 900) check("wdog.err_early", err_o, 0);
        if (done_o) begin
          wdone = 1;
          check("wdog.err_set", err_o, 1);
          check("wdog.inv_valid", inv_valid_o, 1);
          check("wdog.inv_way", inv_way_o, 3'd2);
        end
      end
      check("wdog.done_in_budget", wdone, 1);
      repeat (5) @(negedge clk_i);
      check("wdog.err_sticky", err_o, 1);
      check("wdog.idle", req_ready_o, 1);
      rst_ni = 1'b0;
      @(negedge clk_i);
      check("wdog.err_cleared", err_o, 0);
      rst_ni = 1'b1;
      @(negedge clk_i);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu64_l1_evict.md
Name: cpu64_l1_evict

Overview:
- Eviction/writeback engine for the 8-way L1. It consumes the victim way chosen by the L1 replacement logic and drives the TileLink C channel.
- Dirty lines go out as ReleaseData and clean lines as data-less Release. The block waits for ReleaseAck on D, then commands tag invalidation of the evicted way.
- It sits between the L1 miss controller (request side), the L1 data array (read port) and the TL-C/TL-D ports.

Parameters:
- INDEX_W, 5, set index width.
- TAG_W, 21, tag width.
- SOURCE_ID, 0, TL source id driven on C.
- Fixed: 64-byte line, 64-bit beat, 8 beats, c_size_o = 6, ADDR_W = TAG_W+INDEX_W+6.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  eviction request
- req_ready_o  out  1  engine idle, can accept
- req_set_i  in  INDEX_W  victim set
- req_way_i  in  3  victim way
- req_tag_i  in  TAG_W  victim tag
- req_dirty_i  in  1  victim line dirty
- req_perm_i  in  2  victim permission: 0=N, 1=B, 2=T (3 treated as T)
- da_re_o  out  1  data array read strobe
- da_set_o  out  INDEX_W  read set
- da_way_o  out  3  read way
- da_beat_o  out  3  read beat index
- da_rdata_i  in  64  read data, valid exactly 1 cycle after da_re_o
- c_valid_o  out  1  TL-C valid
- c_ready_i  in  1  TL-C ready
- c_opcode_o  out  3  6=Release, 7=ReleaseData
- c_param_o  out  3  0=TtoB, 1=TtoN, 2=BtoN
- c_size_o  out  3  constant 6
- c_source_o  out  4  SOURCE_ID
- c_address_o  out  ADDR_W  {tag, set, 6'b0}
- c_data_o  out  64  beat data
- d_valid_i  in  1  TL-D valid
- d_opcode_i  in  3  TL-D opcode
- d_ready_o  out  1  TL-D ready
- inv_valid_o  out  1  one-cycle pulse: invalidate inv_set_o/inv_way_o
- inv_set_o  out  INDEX_W  invalidation set
- inv_way_o  out  3  invalidation way
- done_o  out  1  one-cycle pulse: eviction complete
- err_o  out  1  sticky watchdog error (optional feature only)

Behaviour:
- Reset: state IDLE, beat counter 0, request registers 0. c_valid_o, da_re_o, d_ready_o, inv_valid_o, done_o and err_o are 0; req_ready_o is 1.
- req_ready_o = (state==IDLE). A request is accepted on req_valid_i && req_ready_o; set, way, tag, dirty and perm are latched.
- FSM states: IDLE, RD, SEND, WAIT_ACK, FIN.
- IDLE, on accept:
  - perm==N: go to FIN; no C traffic.
  - perm!=N and dirty: go to RD with beat=0.
  - perm!=N and clean: go to SEND.
- RD:
  - Assert da_re_o for exactly 1 cycle with latched set, way and current beat.
  - Next cycle, da_rdata_i is captured into the beat register; go to SEND.
- SEND:
  - c_valid_o=1. Opcode 7 if dirty, else 6.
  - Param: 1 (TtoN) if perm==T; 2 (BtoN) if perm==B.
  - c_address_o, c_size_o and c_source_o stay constant for the whole message.
  - c_data_o = captured beat when dirty, else 0.
  - All C outputs hold stable while c_valid_o && !c_ready_i.
  - On handshake with dirty && beat<7: beat++, go to RD.
  - On handshake otherwise (dirty && beat==7, or clean): go to WAIT_ACK.
- Throughput: one data beat per 2 cycles minimum. A dirty eviction with c_ready_i held at 1 spends 16 cycles from accept to entering WAIT_ACK.
- WAIT_ACK:
  - d_ready_o = d_valid_i-independent term (state==WAIT_ACK) && d_opcode_i==6.
  - Other D opcodes are not consumed.
  - On d_valid_i && d_ready_o: go to FIN.
- FIN: pulse inv_valid_o and done_o for 1 cycle with latched set/way; go to IDLE. req_ready_o rises the following cycle.
- Way never changes mid-eviction; new requests are ignored while busy (req_ready_o=0).
- A d_valid_i that arrives while in SEND is not accepted until WAIT_ACK.
- Reset mid-operation aborts immediately to IDLE. No inv/done pulse is emitted.

Optional Feature:
- Macro CPU64_L1_EVICT_WDOG_EN, defined: 10-bit counter cleared on entry to WAIT_ACK and incremented each WAIT_ACK cycle.
  - When it reaches 1023 with no ack: set err_o (sticky until reset) and go to FIN.
  - FIN still pulses inv/done so the cache does not hang.
- Macro not defined: no counter; err_o tied 0; WAIT_ACK waits indefinitely.

Test Plan:
- Dirty T line, set=3, way=5, tag=0x1ABCD, c_ready_i=1, ack 2 cycles later:
  - Expect 8 beats with opcode 7, param 1, address {0x1ABCD,5'd3,6'd0}, data matching array beats 0..7.
  - Expect da_beat_o 0..7 in order.
  - Expect inv_valid_o pulse with set=3, way=5, and done_o in the same cycle.
- Clean B line: expect exactly one C beat with opcode 6, param 2, c_data_o=0; no da_re_o.
- perm=N request: no c_valid_o, no da_re_o; done_o and inv_valid_o pulse 2 cycles after accept.
- Dirty line with c_ready_i low for 3 cycles on beat 4: C outputs stay stable during the stall; beat 4 data is correct; total beats=8.
- In WAIT_ACK, drive d_opcode_i=1 then 6:
  - Opcode 1: d_ready_o=0, state stays WAIT_ACK.
  - Opcode 6: accepted, then FIN.
  - Separately, assert rst_ni low in beat 3: all outputs return to reset values and req_ready_o=1 after release.
- With CPU64_L1_EVICT_WDOG_EN defined, withhold ack: err_o=1 after 1023 WAIT_ACK cycles, done_o pulses, and err_o stays 1 until reset.
